// File: rtl/afifo_pkg.sv
// Shared types and helpers for the async FIFO write-side arbiter.
// Holds the arbiter state encoding and the wrapping round-robin search.
package afifo_pkg;

   localparam int DSIZE_DEF = 24;
   localparam int RR_MAX    = 8;

   typedef enum logic {IDLE, OWN} arb_state_t;

   // Returns {found, index} of the first set bit at or after ptr, wrapping modulo n.
   function automatic logic [3:0] rr_first(input logic [RR_MAX-1:0] req,
                                           input logic [2:0] ptr, input int n);
      logic [3:0] res;
      int         j;
      res = '0;
      // Walk from the far end so the nearest candidate is written last.
      for (int k = RR_MAX-1; k >= 0; k--) begin
         if (k < n) begin
            j = int'(ptr) + k;
            if (j >= n) j = j - n;
            if (req[j]) res = {1'b1, 3'(j)};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first requester at or after ptr, wrapping.
module rr_pick
   import afifo_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic            found,
   output logic [IDW-1:0]  idx
);

   logic [3:0] res;

   assign res   = rr_first(RR_MAX'(req), 3'(ptr), NREQ);
   assign found = res[3];
   assign idx   = IDW'(res[2:0]);

endmodule

// File: rtl/afifo_wr_arb.sv
// Round-robin, burst-granular arbiter sharing the async FIFO write port among
// NREQ producers; one idle arbitration cycle separates consecutive owners.
module afifo_wr_arb
   import afifo_pkg::*;
#(
   parameter  int DSIZE = DSIZE_DEF,
   parameter  int NREQ  = 4,
   parameter  int BURST = 4,
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic                  wclk,
   input  logic                  wrst_n,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*DSIZE-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   input  logic                  fifo_wfull,
   output logic                  fifo_winc,
   output logic [DSIZE-1:0]      fifo_wdata,
   output logic [IDW-1:0]        gnt_id,
   output logic                  busy
);

   localparam int CW = $clog2(BURST) + 1;

   arb_state_t                   state, state_nxt;
   logic [IDW-1:0]               rr_ptr, owner, pick_idx;
   logic [CW-1:0]                count;
   logic                         pick_found, own_vld, xfer, last, release_own;
   logic [NREQ-1:0][DSIZE-1:0]   data_arr;

   assign data_arr = req_data;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign own_vld = req_valid[owner];
   // Write enable is gated by wfull combinationally, never through a register.
   assign xfer    = (state == OWN) && own_vld && !fifo_wfull;
   assign last    = (count == CW'(BURST-1));

   always_comb begin
      state_nxt   = state;
      busy        = 1'b0;
      gnt_id      = '0;
      req_ready   = '0;
      fifo_winc   = 1'b0;
      fifo_wdata  = '0;
      release_own = 1'b0;
      case (state)
         IDLE: if (pick_found) state_nxt = OWN;
         OWN: begin
            busy             = 1'b1;
            gnt_id           = owner;
            req_ready[owner] = !fifo_wfull;
            fifo_winc        = xfer;
            fifo_wdata       = data_arr[owner];
            release_own      = !own_vld || (xfer && last);
            if (release_own) state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         state  <= IDLE;
         rr_ptr <= '0;
         owner  <= '0;
         count  <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && pick_found) begin
            owner <= pick_idx;
            count <= '0;
         end
         if (release_own) begin
            rr_ptr <= (owner == IDW'(NREQ-1)) ? '0 : owner + 1'b1;
            count  <= '0;
         end else if (xfer) begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_afifo_wr_arb.sv
// Randomized bench for afifo_wr_arb against a transaction-level reference model.
module tb_afifo_wr_arb;

   localparam int DSIZE = 24;
   localparam int NREQ  = 4;
   localparam int BURST = 4;
   localparam int IDW   = 2;

   logic                  wclk = 1'b0;
   logic                  wrst_n = 1'b0;
   logic [NREQ-1:0]       req_valid = '0;
   logic [NREQ*DSIZE-1:0] req_data = '0;
   logic [NREQ-1:0]       req_ready;
   logic                  fifo_wfull = 1'b0;
   logic                  fifo_winc;
   logic [DSIZE-1:0]      fifo_wdata;
   logic [IDW-1:0]        gnt_id;
   logic                  busy;

   afifo_wr_arb #(.DSIZE(DSIZE), .NREQ(NREQ), .BURST(BURST)) dut (
      .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .fifo_wfull(fifo_wfull), .fifo_winc(fifo_winc),
      .fifo_wdata(fifo_wdata), .gnt_id(gnt_id), .busy(busy)
   );

   always #5 wclk = ~wclk;

   int vectors = 0;
   int errors  = 0;

   // Reference model: who owns the port, how many words it has sent, whose turn is next.
   bit               m_own;
   int               m_owner, m_sent, m_next;
   logic             e_busy, e_winc;
   logic [IDW-1:0]   e_gnt;
   logic [NREQ-1:0]  e_ready;
   logic [DSIZE-1:0] e_wdata;
   logic [DSIZE-1:0] word [NREQ];

   task automatic model_reset();
      m_own = 0; m_owner = 0; m_sent = 0; m_next = 0;
   endtask

   task automatic model_outputs();
      e_busy = 0; e_gnt = '0; e_ready = '0; e_winc = 0; e_wdata = '0;
      if (m_own) begin
         e_busy           = 1;
         e_gnt            = IDW'(m_owner);
         e_ready[m_owner] = !fifo_wfull;
         e_winc           = req_valid[m_owner] && !fifo_wfull;
         e_wdata          = word[m_owner];
      end
   endtask

   task automatic model_advance();
      if (!m_own) begin
         for (int k = 0; k < NREQ; k++) begin
            if (!m_own && req_valid[(m_next + k) % NREQ]) begin
               m_own = 1; m_owner = (m_next + k) % NREQ; m_sent = 0;
            end
         end
      end else if (!req_valid[m_owner]) begin
         m_own = 0; m_next = (m_owner + 1) % NREQ; m_sent = 0;
      end else if (!fifo_wfull) begin
         word[m_owner] = DSIZE'($urandom);
         m_sent++;
         if (m_sent == BURST) begin
            m_own = 0; m_next = (m_owner + 1) % NREQ; m_sent = 0;
         end
      end
   endtask

   function automatic string got_exp();
      return $sformatf("got busy=%b gnt=%0d rdy=%b winc=%b wdata=%h, exp busy=%b gnt=%0d rdy=%b winc=%b wdata=%h",
                       busy, gnt_id, req_ready, fifo_winc, fifo_wdata,
                       e_busy, e_gnt, e_ready, e_winc, e_wdata);
   endfunction

   // Drives data for the current inputs, then samples at the falling edge.
   task automatic cycle_begin();
      for (int i = 0; i < NREQ; i++) begin
         if (!req_valid[i]) word[i] = DSIZE'($urandom);
         req_data[i*DSIZE +: DSIZE] = word[i];
      end
      @(negedge wclk);
      model_outputs();
   endtask

   task automatic cycle_end();
      model_advance();
      @(posedge wclk);
      #1;
   endtask

   task automatic do_reset();
      wrst_n = 0; req_valid = '0; fifo_wfull = 0;
      model_reset();
      repeat (2) @(posedge wclk);
      @(negedge wclk);
      wrst_n = 1;
      @(posedge wclk);
      #1;
   endtask

   task automatic test_reset();
      wrst_n = 0; req_valid = '1; fifo_wfull = 0;
      model_reset();
      for (int c = 0; c < 3; c++) begin
         cycle_begin();
         vectors++;
         if ({busy, gnt_id, req_ready, fifo_winc, fifo_wdata} !== '0) begin
            errors++; $display("FAIL reset c%0d %s", c, got_exp());
         end
         @(posedge wclk); #1;
      end
      do_reset();
   endtask

   task automatic test_single();
      int left = 6;
      logic [9:0] pat = '0, exp_pat = 10'b0011011110;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         req_valid = (left > 0) ? 4'b0001 : 4'b0000;
         cycle_begin();
         vectors++;
         if ({busy, gnt_id, req_ready, fifo_winc, fifo_wdata} !== {e_busy, e_gnt, e_ready, e_winc, e_wdata}) begin
            errors++; $display("FAIL single c%0d %s", c, got_exp());
         end
         pat[c] = fifo_winc;
         if (e_winc) left--;
         cycle_end();
      end
      vectors++;
      if (pat !== exp_pat) begin
         errors++; $display("FAIL single_timing got %b exp %b", pat, exp_pat);
      end
   endtask

   task automatic test_all_valid();
      int n = 0;
      logic [IDW-1:0] seq [20];
      do_reset();
      req_valid = '1;
      for (int c = 0; c < 25; c++) begin
         cycle_begin();
         vectors++;
         if ({busy, gnt_id, req_ready, fifo_winc, fifo_wdata} !== {e_busy, e_gnt, e_ready, e_winc, e_wdata}) begin
            errors++; $display("FAIL all_valid c%0d %s", c, got_exp());
         end
         if (fifo_winc === 1'b1 && n < 20) begin seq[n] = gnt_id; n++; end
         cycle_end();
      end
      vectors++;
      if (n != 20) begin
         errors++; $display("FAIL all_valid_count got %0d exp 20", n);
      end
      for (int k = 0; k < n; k++) begin
         vectors++;
         if (seq[k] !== IDW'((k / BURST) % NREQ)) begin
            errors++; $display("FAIL all_valid_order word%0d got %0d exp %0d", k, seq[k], (k / BURST) % NREQ);
         end
      end
   endtask

   task automatic test_wfull();
      int wincs = 0;
      do_reset();
      req_valid = 4'b0100;
      for (int c = 0; c < 9; c++) begin
         fifo_wfull = (c >= 3 && c <= 5);
         cycle_begin();
         vectors++;
         if ({busy, gnt_id, req_ready, fifo_winc, fifo_wdata} !== {e_busy, e_gnt, e_ready, e_winc, e_wdata}) begin
            errors++; $display("FAIL wfull c%0d %s", c, got_exp());
         end
         if (fifo_winc === 1'b1) wincs++;
         if (c == 8) begin
            vectors++;
            if (busy !== 1'b0) begin
               errors++; $display("FAIL wfull_release got busy=%b exp 0", busy);
            end
         end
         cycle_end();
      end
      fifo_wfull = 0;
      vectors++;
      if (wincs != BURST) begin
         errors++; $display("FAIL wfull_words got %0d exp %0d", wincs, BURST);
      end
   endtask

   task automatic test_drop();
      int wincs = 0;
      do_reset();
      for (int c = 0; c < 6; c++) begin
         req_valid = {1'b1, 1'b0, (c < 3), 1'b0};
         cycle_begin();
         vectors++;
         if ({busy, gnt_id, req_ready, fifo_winc, fifo_wdata} !== {e_busy, e_gnt, e_ready, e_winc, e_wdata}) begin
            errors++; $display("FAIL drop c%0d %s", c, got_exp());
         end
         if (c <= 4 && fifo_winc === 1'b1) wincs++;
         if (c == 5) begin
            vectors++;
            if ({busy, gnt_id, fifo_winc} !== {1'b1, 2'd3, 1'b1}) begin
               errors++; $display("FAIL drop_next got busy=%b gnt=%0d winc=%b exp 1/3/1", busy, gnt_id, fifo_winc);
            end
         end
         cycle_end();
      end
      vectors++;
      if (wincs != 2) begin
         errors++; $display("FAIL drop_words got %0d exp 2", wincs);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int c = 0; c < 8; c++) begin
         req_valid = (c < 5) ? 4'b0100 : 4'b0101;
         cycle_begin();
         vectors++;
         if ({busy, gnt_id, req_ready, fifo_winc, fifo_wdata} !== {e_busy, e_gnt, e_ready, e_winc, e_wdata}) begin
            errors++; $display("FAIL wrap c%0d %s", c, got_exp());
         end
         if (c == 6) begin
            vectors++;
            if ({busy, gnt_id} !== {1'b1, 2'd0}) begin
               errors++; $display("FAIL wrap_owner got busy=%b gnt=%0d exp 1/0", busy, gnt_id);
            end
         end
         cycle_end();
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      req_valid = 4'b0100;
      for (int c = 0; c < 3; c++) begin
         cycle_begin();
         vectors++;
         if ({busy, gnt_id, req_ready, fifo_winc, fifo_wdata} !== {e_busy, e_gnt, e_ready, e_winc, e_wdata}) begin
            errors++; $display("FAIL reset_mid c%0d %s", c, got_exp());
         end
         cycle_end();
      end
      #2;
      wrst_n = 0;
      #1;
      vectors++;
      if ({busy, gnt_id, req_ready, fifo_winc, fifo_wdata} !== '0) begin
         errors++; $display("FAIL reset_async got busy=%b gnt=%0d rdy=%b winc=%b wdata=%h exp all 0",
                            busy, gnt_id, req_ready, fifo_winc, fifo_wdata);
      end
      req_valid = '0;
      model_reset();
      @(negedge wclk);
      wrst_n = 1;
      @(posedge wclk);
      #1;
      req_valid = '1;
      for (int c = 0; c < 6; c++) begin
         cycle_begin();
         vectors++;
         if ({busy, gnt_id, req_ready, fifo_winc, fifo_wdata} !== {e_busy, e_gnt, e_ready, e_winc, e_wdata}) begin
            errors++; $display("FAIL reset_mid_after c%0d %s", c, got_exp());
         end
         if (c == 1) begin
            vectors++;
            if ({busy, gnt_id} !== {1'b1, 2'd0}) begin
               errors++; $display("FAIL reset_mid_owner got busy=%b gnt=%0d exp 1/0", busy, gnt_id);
            end
         end
         cycle_end();
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NREQ; i++) req_valid[i] = ($urandom_range(0, 3) != 0);
         fifo_wfull = ($urandom_range(0, 3) == 0);
         cycle_begin();
         vectors++;
         if ({busy, gnt_id, req_ready, fifo_winc, fifo_wdata} !== {e_busy, e_gnt, e_ready, e_winc, e_wdata}) begin
            errors++; $display("FAIL random c%0d %s", c, got_exp());
         end
         vectors++;
         if (fifo_winc === 1'b1 && fifo_wfull === 1'b1) begin
            errors++; $display("FAIL random_winc_full c%0d got winc=1 exp 0", c);
         end
         cycle_end();
      end
   endtask

   initial begin
      for (int i = 0; i < NREQ; i++) word[i] = '0;
      model_reset();
      test_reset();
      test_single();
      test_all_valid();
      test_wfull();
      test_drop();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
